pll_dyn_ctrl: RTL

PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

---
 rtl/pll_dyn_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pll_dyn_ctrl.sv
// PLL reset/lock supervisor with dynamic phase stepping (PSDA) and 50% duty tracking (DUTYDA).
// Optional loss-of-lock counter enabled by defining PLL_LOSS_CNT_EN.
module pll_dyn_ctrl #(
  parameter int PS_W        = 4,
  parameter int PLL_RST_CYC = 16,
  parameter int LOCK_FILT   = 64,
  parameter int LOCK_TMO    = 65535,
  parameter int MAX_RETRY   = 3,
  parameter int SETTLE_CYC  = 32
) (
  input  logic            clkin,
  input  logic            reset_n,
  input  logic            pll_lock_i,
  output logic            pll_reset_o,
  output logic [PS_W-1:0] psda_o,
  output logic [PS_W-1:0] dutyda_o,
  input  logic            ps_req_i,
  input  logic            ps_dir_i,
  output logic            ps_ack_o,
  output logic            locked_o,
  output logic            sys_rst_n_o,
  output logic            fault_o
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [7:0]      lock_loss_cnt_o
`endif
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_LOCKED = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam int CNT_W = $clog2(PLL_RST_CYC + SETTLE_CYC + 1);
  localparam int FLT_W = $clog2(LOCK_FILT + 1);
  localparam int TMO_W = $clog2(LOCK_TMO + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
  localparam logic [PS_W-1:0] PS_HALF = {1'b1, {(PS_W-1){1'b0}}};

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [FLT_W-1:0] fcnt, fcnt_n;
  logic [TMO_W-1:0] tcnt, tcnt_n;
  logic [RTY_W-1:0] retry, retry_n, retry_inc;
  logic [PS_W-1:0]  psda_n;
  logic             ack_n;
  logic             locked_n;

  assign retry_inc = retry + RTY_W'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fcnt_n  = fcnt;
    tcnt_n  = tcnt;
    retry_n = retry;
    psda_n  = psda_o;
    ack_n   = 1'b0;
    case (state)
      S_RST: begin
        if (cnt == CNT_W'(PLL_RST_CYC - 1)) begin
          state_n = S_WAIT;
          cnt_n   = '0;
          fcnt_n  = '0;
          tcnt_n  = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_WAIT: begin
        // A completed filter run wins over a timeout landing on the same cycle.
        if (pll_lock_i && (fcnt == FLT_W'(LOCK_FILT - 1))) begin
          state_n = S_LOCKED;
          retry_n = '0;
        end else if (tcnt == TMO_W'(LOCK_TMO - 1)) begin
          retry_n = retry_inc;
          state_n = (retry_inc == RTY_W'(MAX_RETRY)) ? S_FAULT : S_RST;
          cnt_n   = '0;
        end else begin
          fcnt_n = pll_lock_i ? fcnt + FLT_W'(1) : '0;
          tcnt_n = tcnt + TMO_W'(1);
        end
      end
      S_LOCKED: begin
        if (!pll_lock_i) begin
          state_n = S_RST;
          cnt_n   = '0;
        end else if (ps_req_i) begin
          ack_n   = 1'b1;
          psda_n  = ps_dir_i ? psda_o + PS_ONE : psda_o - PS_ONE;
          state_n = S_SETTLE;
          cnt_n   = '0;
        end
      end
      S_SETTLE: begin
        // The ack cycle plus SETTLE_CYC wait cycles before a new request is sampled.
        if (!pll_lock_i) begin
          state_n = S_RST;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(SETTLE_CYC)) begin
          state_n = S_LOCKED;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_FAULT: begin
        state_n = S_FAULT;
      end
      default: begin
        state_n = S_RST;
        cnt_n   = '0;
      end
    endcase
  end

  assign locked_n = (state_n == S_LOCKED) || (state_n == S_SETTLE);

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state       <= S_RST;
      cnt         <= '0;
      fcnt        <= '0;
      tcnt        <= '0;
      retry       <= '0;
      psda_o      <= '0;
      dutyda_o    <= PS_HALF;
      pll_reset_o <= 1'b1;
      ps_ack_o    <= 1'b0;
      locked_o    <= 1'b0;
      sys_rst_n_o <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      fcnt        <= fcnt_n;
      tcnt        <= tcnt_n;
      retry       <= retry_n;
      psda_o      <= psda_n;
      dutyda_o    <= psda_n + PS_HALF;
      pll_reset_o <= (state_n == S_RST) || (state_n == S_FAULT);
      ps_ack_o    <= ack_n;
      locked_o    <= locked_n;
      // Rises one stage after locked_o, falls together with it.
      sys_rst_n_o <= locked_o && locked_n;
      fault_o     <= (state_n == S_FAULT);
    end
  end

`ifdef PLL_LOSS_CNT_EN
  logic lost;
  assign lost = ((state == S_LOCKED) || (state == S_SETTLE)) && !pll_lock_i;

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      lock_loss_cnt_o <= 8'd0;
    end else if (lost && (lock_loss_cnt_o != 8'hFF)) begin
      lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
    end
  end
`endif

endmodule
